// File: rtl/bram_rd_pkg.sv
// Shared types and helpers for the BRAM stream reader: FSM encoding,
// default RAM read latency and the width helper used for address/length ports.
package bram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_t;

    localparam int DEF_LATENCY = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream carrying realigned RAM read data with a last-beat marker.
interface bram_stream_reader_if #(
    parameter int RAM_WIDTH = 32
);
    logic [RAM_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/bram_rd_skid_fifo.sv
// Shift-down skid FIFO: entry 0 is the registered head, so the output is
// stable while stalled and a push into an empty FIFO shows up one cycle later.
module bram_rd_skid_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clka,
    input  logic             rstb,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] entries [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && (!full || pop_ok);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = entries[0];

    always_ff @(posedge clka) begin
        if (rstb) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pop_ok) begin
                    // On a pop the write slot moves down with the rest of the queue.
                    if (push_ok && (CNT_W'(i) == count - 1'b1))
                        entries[i] <= push_data;
                    else if (i < DEPTH - 1)
                        entries[i] <= entries[(i < DEPTH - 1) ? i + 1 : i];
                end else if (push_ok && (CNT_W'(i) == count)) begin
                    entries[i] <= push_data;
                end
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// Walks an address range on one read port of a pipelined BRAM and realigns
// the returned data into a valid/ready stream, using credits to bound in-flight reads.
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int  RAM_WIDTH  = 32,
    parameter int  RAM_DEPTH  = 1024,
    parameter int  LATENCY    = DEF_LATENCY,
    parameter int  FIFO_DEPTH = LATENCY + 2,
    localparam int ADDR_W     = clog2(RAM_DEPTH),
    localparam int LEN_W      = ADDR_W + 1
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic                 ram_regce,
    input  logic [RAM_WIDTH-1:0] ram_dout,
    bram_stream_reader_if.master strm
);
    localparam int OCC_W = clog2(FIFO_DEPTH + 1);

    rd_state_t            state;
    logic [ADDR_W-1:0]    next_addr;
    logic [LEN_W-1:0]     remaining;
    logic [OCC_W-1:0]     outstanding;
    logic                 ram_last;
    logic [LATENCY-1:0]   vld_sr;
    logic [LATENCY-1:0]   last_sr;
    logic                 pop;
    logic                 credit_ok;
    logic                 accept;
    logic                 issue_any;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [OCC_W-1:0]     fifo_count;
    logic [RAM_WIDTH:0]   head;
    logic                 unused_fifo;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(RAM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    assign ram_we    = 1'b0;
    assign ram_regce = 1'b1;

    assign pop       = strm.m_valid && strm.m_ready;
    // A beat leaving this cycle frees its credit for the issue decided this cycle.
    assign credit_ok = (outstanding < OCC_W'(FIFO_DEPTH)) || pop;
    assign accept    = (state == IDLE) && start && !done;
    assign issue_any = ((state == RUN) && credit_ok) || (accept && (length != '0));

    always_ff @(posedge clka) begin
        if (rstb) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_en      <= 1'b0;
            ram_addr    <= '0;
            ram_last    <= 1'b0;
            next_addr   <= '0;
            remaining   <= '0;
            outstanding <= '0;
            vld_sr      <= '0;
            last_sr     <= '0;
        end else begin
            done        <= 1'b0;
            ram_en      <= 1'b0;
            ram_last    <= 1'b0;
            vld_sr      <= (vld_sr << 1) | LATENCY'(ram_en);
            last_sr     <= (last_sr << 1) | LATENCY'(ram_en && ram_last);
            outstanding <= outstanding + OCC_W'(issue_any) - OCC_W'(pop);
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            ram_en    <= 1'b1;
                            ram_addr  <= base_addr;
                            ram_last  <= (length == LEN_W'(1));
                            next_addr <= addr_inc(base_addr);
                            remaining <= length - 1'b1;
                            state     <= (length == LEN_W'(1)) ? DRAIN : RUN;
                        end
                    end
                end
                RUN: begin
                    if (credit_ok) begin
                        ram_en    <= 1'b1;
                        ram_addr  <= next_addr;
                        next_addr <= addr_inc(next_addr);
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            ram_last <= 1'b1;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && strm.m_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM output stage: data lands in the skid FIFO when its tracking bit exits.
    bram_rd_skid_fifo #(
        .WIDTH (RAM_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (OCC_W)
    ) u_fifo (
        .clka      (clka),
        .rstb      (rstb),
        .push      (vld_sr[LATENCY-1]),
        .push_data ({last_sr[LATENCY-1], ram_dout}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign strm.m_valid = !fifo_empty;
    assign strm.m_data  = head[RAM_WIDTH-1:0];
    assign strm.m_last  = head[RAM_WIDTH] && !fifo_empty;
    assign unused_fifo  = ^{fifo_full, fifo_count};
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a 2-cycle BRAM model feeds the DUT and every
// beat, issue address and timing point is compared against address-range expectations.
module tb_bram_stream_reader;
    import bram_rd_pkg::*;

    localparam int RAM_WIDTH = 32;
    localparam int RAM_DEPTH = 1024;
    localparam int LATENCY   = 2;
    localparam int CREDITS   = LATENCY + 2;
    localparam int ADDR_W    = 10;
    localparam int LEN_W     = 11;

    logic                 clka = 1'b0;
    logic                 rstb = 1'b1;
    logic                 start = 1'b0;
    logic [ADDR_W-1:0]    base_addr = '0;
    logic [LEN_W-1:0]     length = '0;
    logic                 busy;
    logic                 done;
    logic [ADDR_W-1:0]    ram_addr;
    logic                 ram_en;
    logic                 ram_we;
    logic                 ram_regce;
    logic [RAM_WIDTH-1:0] ram_dout;

    bram_stream_reader_if #(.RAM_WIDTH(RAM_WIDTH)) strm ();

    bram_stream_reader #(
        .RAM_WIDTH (RAM_WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .LATENCY   (LATENCY)
    ) dut (
        .clka      (clka),
        .rstb      (rstb),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_regce (ram_regce),
        .ram_dout  (ram_dout),
        .strm      (strm)
    );

    always #5 clka = ~clka;

    // Read-first BRAM in 2-cycle mode: array read register then output register.
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_q;
    always @(posedge clka) begin
        if (ram_en) ram_q <= mem[ram_addr];
        if (ram_regce) ram_dout <= ram_q;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // Launches one transfer in the current cycle (cycle 0) and follows it to done.
    task automatic run_xfer(input int b, input int len, input int rdy_pct,
                            input bit chk_timing, input int poke_cyc, output int stalls);
        int issued, beats, first_v, done_cyc, max_out, t, idx;
        bit prev_stall, prev_last;
        logic [RAM_WIDTH-1:0] prev_data;
        issued = 0; beats = 0; first_v = -1; done_cyc = -1; max_out = 0; stalls = 0;
        prev_stall = 0; prev_last = 0; prev_data = '0;
        start = 1'b1;
        base_addr = ADDR_W'(b);
        length = LEN_W'(len);
        step();
        start = 1'b0;
        t = 1;
        while (t < 3000) begin
            strm.m_ready = ($urandom_range(99) < rdy_pct);
            if (t == poke_cyc) begin
                start = 1'b1;
                base_addr = ADDR_W'($urandom);
                length = LEN_W'($urandom_range(40, 1));
            end else begin
                start = 1'b0;
            end
            if (ram_en) begin
                if (issued < len)
                    chk("issue_addr", 64'(ram_addr), 64'((b + issued) % RAM_DEPTH));
                else
                    chk("extra_issue", 64'(issued), 64'(len - 1));
                issued++;
                if (chk_timing && issued == 1) chk("first_issue_cycle", 64'(t), 64'd1);
            end else if (busy && issued < len) begin
                stalls++;
            end
            if (issued - beats > max_out) max_out = issued - beats;
            if (prev_stall) begin
                chk("stall_data_stable", 64'(strm.m_data), 64'(prev_data));
                chk("stall_last_stable", 64'(strm.m_last), 64'(prev_last));
            end
            if (strm.m_valid && first_v < 0) first_v = t;
            if (strm.m_valid && strm.m_ready) begin
                if (beats < len) begin
                    idx = (b + beats) % RAM_DEPTH;
                    chk("beat_data", 64'(strm.m_data), 64'(mem[idx]));
                    chk("beat_last", 64'(strm.m_last), 64'(beats == len - 1));
                end else begin
                    chk("extra_beat", 64'(beats), 64'(len - 1));
                end
                beats++;
            end
            prev_stall = strm.m_valid && !strm.m_ready;
            prev_data  = strm.m_data;
            prev_last  = strm.m_last;
            if (done) begin
                done_cyc = t;
                chk("busy_at_done", 64'(busy), 64'd0);
                break;
            end
            chk("busy_level", 64'(busy), 64'(len > 0));
            step();
            t++;
        end
        start = 1'b0;
        chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("beat_count", 64'(beats), 64'(len));
        chk("issue_count", 64'(issued), 64'(len));
        chk("outstanding_bound", 64'(max_out <= CREDITS), 64'd1);
        if (chk_timing) begin
            if (len > 0) begin
                chk("first_valid_cycle", 64'(first_v), 64'(LATENCY + 2));
                chk("done_cycle", 64'(done_cyc), 64'(len + LATENCY + 2));
            end else begin
                chk("done_cycle_len0", 64'(done_cyc), 64'd1);
            end
        end
        if (len == 0) chk("no_valid_len0", 64'(first_v < 0), 64'd1);
    endtask

    int stalls;

    initial begin
        strm.m_ready = 1'b0;
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = $urandom;

        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_regce", 64'(ram_regce), 64'd1);
        chk("rst_m_valid", 64'(strm.m_valid), 64'd0);
        chk("rst_m_last", 64'(strm.m_last), 64'd0);
        chk("rst_m_data", 64'(strm.m_data), 64'd0);
        rstb = 1'b0;
        repeat (2) step();

        run_xfer(32'h010, 8, 100, 1, -1, stalls);
        step();
        run_xfer(32'h3FE, 4, 100, 1, -1, stalls);
        step();
        run_xfer(32'h040, 16, 30, 0, -1, stalls);
        chk("credit_stall_seen", 64'(stalls > 0), 64'd1);
        step();
        run_xfer(32'h123, 0, 100, 1, -1, stalls);
        step();

        // Start during a transfer, then start coinciding with done: both ignored.
        run_xfer(32'h200, 10, 100, 1, 5, stalls);
        start = 1'b1;
        base_addr = ADDR_W'(32'h055);
        length = LEN_W'(5);
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("start_at_done_busy", 64'(busy), 64'd0);
            chk("start_at_done_en", 64'(ram_en), 64'd0);
            step();
        end

        // Reset three cycles into a long transfer; in-flight reads must vanish.
        start = 1'b1;
        base_addr = ADDR_W'(32'h2A0);
        length = LEN_W'(32);
        strm.m_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        rstb = 1'b1;
        step();
        rstb = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ram_en", 64'(ram_en), 64'd0);
        chk("midrst_m_valid", 64'(strm.m_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_valid", 64'(strm.m_valid), 64'd0);
        end
        run_xfer(32'h100, 2, 100, 1, -1, stalls);
        step();

        for (int k = 0; k < 6; k++) begin
            run_xfer(int'($urandom_range(RAM_DEPTH - 1)), int'($urandom_range(40, 1)),
                     int'($urandom_range(90, 20)), 0, -1, stalls);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Sequential read engine for one port of the team's dual-port read-first BRAM in HIGH_PERFORMANCE (2-cycle) mode. On a start command it walks an address range, issues one read per cycle, and realigns the pipelined RAM output into a valid/ready stream with last-beat marking. A credit-limited skid FIFO absorbs in-flight reads when the consumer stalls. It sits directly upstream of the RAM address/enable pins and downstream of the RAM data output.

## Interface
- RAM_WIDTH, 32, data width; must match the RAM instance.
- RAM_DEPTH, 1024, RAM entries; ADDR_W = clog2(RAM_DEPTH), LEN_W = ADDR_W+1.
- LATENCY, 2, RAM read latency in cycles from address to valid douta; legal range 1..4.
- FIFO_DEPTH, LATENCY+2, skid FIFO entries; must be ≥ LATENCY+1.

Ports:
- clka  in  1  clock for the whole block and the RAM port.
- rstb  in  1  reset, synchronous, active-high (clock clka).
- start  in  1  one-cycle command pulse; ignored while busy=1.
- base_addr  in  ADDR_W  first address, sampled with start.
- length  in  LEN_W  beat count, 0..RAM_DEPTH, sampled with start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of transfer.
- ram_addr  out  ADDR_W  RAM address.
- ram_en  out  1  RAM port enable; high only on issue cycles.
- ram_we  out  1  constant 0.
- ram_regce  out  1  constant 1.
- ram_dout  in  RAM_WIDTH  RAM output data.
- m_data  out  RAM_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final beat.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: on start with length>0, latch base_addr and length, then go to RUN. On start with length=0, pulse done in the next cycle and stay in IDLE.
- RUN: issue a read when outstanding < FIFO_DEPTH. Issuing means ram_en=1, ram_addr=current address, address+1, and issue count-1. outstanding = in-flight reads + FIFO occupancy, held in a registered counter. When the final read is issued, go to DRAIN.
- DRAIN: wait for the final beat to handshake (m_valid & m_ready & m_last), then pulse done and go to IDLE.
- Address increments modulo RAM_DEPTH; RAM_DEPTH-1 wraps to 0.
- A LATENCY-deep valid shift register tracks issues. When a tracked bit exits, ram_dout is pushed into the FIFO together with a last flag.
- Beat handshake: m_valid & m_ready. m_data and m_last stay stable while m_valid=1 and m_ready=0.
- The credit rule makes FIFO overflow impossible. A simultaneous push and pop keeps occupancy unchanged.
- Reset mid-transfer: the state machine returns to IDLE, counters and FIFO clear, and in-flight RAM data is discarded (tracking bits cleared).

## Timing
- Reset values: busy=0, done=0, ram_en=0, ram_addr=0, ram_we=0, ram_regce=1, m_valid=0, m_last=0, m_data=0.
- start is sampled at cycle 0. The first ram_en/ram_addr appears in cycle 1 and that data is on ram_dout in cycle 1+LATENCY. m_valid rises in cycle 2+LATENCY, which is cycle 4 at the default LATENCY.
- With m_ready held at 1, the block sustains 1 beat/cycle and an N-beat transfer ends with done in cycle N+LATENCY+2.
- done is asserted in the cycle after the last handshake; busy falls in that same cycle.
- start arriving in the same cycle as done is ignored.

## Structure
- Package bram_rd_pkg holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the default LATENCY;
  - the clog2 function used for ADDR_W/LEN_W.
- Sub-module bram_rd_skid_fifo: a synchronous FIFO of width RAM_WIDTH+1 (data plus last) and depth FIFO_DEPTH, with a registered output and full/empty/count outputs.
- The top level holds the FSM, the address and length counters, the outstanding counter and the valid shift register.

## Test plan
- base=0x010, length=8, m_ready=1 → m_data = RAM[0x010..0x017] in order, m_valid first in cycle 4, m_last on beat 8, done in cycle 12.
- base=0x3FE, length=4 → data from addresses 0x3FE, 0x3FF, 0x000, 0x001.
- length=16 with m_ready toggling on a random 30% duty → no lost or duplicated beats, outstanding never exceeds 4, ram_en stalls while credits are exhausted.
- length=0 → done in cycle 1, m_valid never asserted, busy stays 0.
- rstb asserted 3 cycles into a length=32 transfer, then a new start with base=0x100, length=2 → only RAM[0x100] and RAM[0x101] are emitted.
- start pulsed while busy → ignored, and the transfer in progress completes unchanged.
